bcd_frac_to_bin: RTL and testbench



---
 rtl/bcd_frac_to_bin_if.sv | 24 ++
 rtl/bcd_frac_to_bin.sv | 126 ++++++++++++
 tb/tb_bcd_frac_to_bin.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bcd_frac_to_bin_if.sv
// rtl/bcd_frac_to_bin_if.sv - request/result bundle for the BCD fraction to binary converter
interface bcd_frac_to_bin_if #(
    parameter int NDIG  = 5,
    parameter int NBITS = 24
);
    logic                start;
    logic [4*NDIG-1:0]   bcd_in;
    logic                ready;
    logic                done;
    logic [NBITS-1:0]    frac_out;
    logic [4:0]          so_bit_0;
    logic                inexact;
    logic                err;

    modport master (
        output start, bcd_in,
        input  ready, done, frac_out, so_bit_0, inexact, err
    );

    modport slave (
        input  start, bcd_in,
        output ready, done, frac_out, so_bit_0, inexact, err
    );
endinterface

// File: rtl/bcd_frac_to_bin.sv
// rtl/bcd_frac_to_bin.sv - BCD fraction 0.d1..dN to truncated binary fraction by repeated BCD doubling
module bcd_frac_to_bin #(
    parameter int NDIG  = 5,
    parameter int NBITS = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_frac_to_bin_if.slave   bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [4*NDIG-1:0]   r_work;
    logic [4*NDIG-1:0]   w_work_dbl;
    logic [NBITS-1:0]    r_frac_sh;
    logic [4:0]          r_cnt;
    logic                r_bad;
    logic                r_done;
    logic [NBITS-1:0]    r_frac_out;
    logic [4:0]          r_so_bit_0;
    logic                r_inexact;
    logic                r_err;
    logic                w_carry;
    logic                w_bad_in;
    logic                w_accept;
    logic                w_last;
    logic [4:0]          w_lz;

    assign w_accept = (r_state == IDLE) && bus.start;
    // A bad input still passes through SHIFT for one edge so its result lands one edge after accept.
    assign w_last   = (r_state == SHIFT) && (r_bad || (r_cnt == 5'(NBITS)));

    always_comb begin
        logic [4:0] t;
        logic       c;
        c          = 1'b0;
        t          = '0;
        w_work_dbl = '0;
        for (int i = 0; i < NDIG; i++) begin
            t = {r_work[4*i +: 4], 1'b0} + {4'd0, c};
            if (t >= 5'd10) begin
                t = t - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            w_work_dbl[4*i +: 4] = t[3:0];
        end
        w_carry = c;
    end

    always_comb begin
        w_bad_in = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) w_bad_in = 1'b1;
        end
    end

    always_comb begin
        w_lz = 5'(NBITS);
        for (int i = 0; i < NBITS; i++) begin
            if (r_frac_sh[i]) w_lz = 5'(NBITS - 1 - i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_frac_sh  <= '0;
            r_cnt      <= '0;
            r_bad      <= 1'b0;
            r_done     <= 1'b0;
            r_frac_out <= '0;
            r_so_bit_0 <= '0;
            r_inexact  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_work    <= bus.bcd_in;
                r_frac_sh <= '0;
                r_cnt     <= '0;
                r_bad     <= w_bad_in;
            end else if (w_last) begin
                r_done <= 1'b1;
                if (r_bad) begin
                    r_err      <= 1'b1;
                    r_frac_out <= '0;
                    r_so_bit_0 <= 5'(NBITS);
                    r_inexact  <= 1'b0;
                end else begin
                    r_err      <= 1'b0;
                    r_frac_out <= r_frac_sh;
                    r_so_bit_0 <= w_lz;
                    r_inexact  <= |r_work;
                end
            end else if (r_state == SHIFT) begin
                r_work    <= w_work_dbl;
                r_frac_sh <= (r_frac_sh << 1) | NBITS'(w_carry);
                r_cnt     <= r_cnt + 5'd1;
            end
        end
    end

    assign bus.ready    = (r_state == IDLE);
    assign bus.done     = r_done;
    assign bus.frac_out = r_frac_out;
    assign bus.so_bit_0 = r_so_bit_0;
    assign bus.inexact  = r_inexact;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_bcd_frac_to_bin.sv
// tb/tb_bcd_frac_to_bin.sv - scoreboard bench for bcd_frac_to_bin with directed vectors
module tb_bcd_frac_to_bin;
    localparam int NDIG  = 5;
    localparam int NBITS = 24;

    typedef struct {
        logic [NBITS-1:0] frac;
        logic [4:0]       lz;
        logic             inex;
        logic             err;
        int               lat;
        int               acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    bcd_frac_to_bin_if #(.NDIG(NDIG), .NBITS(NBITS)) bus ();

    bcd_frac_to_bin #(.NDIG(NDIG), .NBITS(NBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("frac_out", 32'(bus.frac_out), 32'(e.frac));
                chk("so_bit_0", 32'(bus.so_bit_0), 32'(e.lz));
                chk("inexact",  32'(bus.inexact),  32'(e.inex));
                chk("err",      32'(bus.err),      32'(e.err));
                chk("latency",  32'(cyc - e.acc),  32'(e.lat));
                chk("ready_at_done", 32'(bus.ready), 32'd1);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [4*NDIG-1:0] bcd, input logic [NBITS-1:0] frac,
                         input logic [4:0] lz, input logic inex, input logic err, input int lat);
        exp_t e;
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(negedge clk);
        bus.start  = 1'b0;
        e.frac = frac; e.lz = lz; e.inex = inex; e.err = err; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb.size() == 0 && bus.ready === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done !== 1'b1 && n < 100);
        if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},    32'(bus.ready),    32'd1);
        chk({tag, "_done"},     32'(bus.done),     32'd0);
        chk({tag, "_frac_out"}, 32'(bus.frac_out), 32'd0);
        chk({tag, "_so_bit_0"}, 32'(bus.so_bit_0), 32'd0);
        chk({tag, "_inexact"},  32'(bus.inexact),  32'd0);
        chk({tag, "_err"},      32'(bus.err),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] junk [4];
        junk[0] = 20'h99999; junk[1] = 20'h00000; junk[2] = 20'h12345; junk[3] = 20'h5A000;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(20'h50000, 24'h800000, 5'd0, 1'b0, 1'b0, 25);
        wait_idle();

        issue(20'h10000, 24'h199999, 5'd3, 1'b1, 1'b0, 25);
        wait_done();
        issue(20'h25000, 24'h400000, 5'd1, 1'b0, 1'b0, 25);
        wait_idle();

        issue(20'h00001, 24'h0000A7, 5'd16, 1'b1, 1'b0, 25);
        wait_idle();
        issue(20'h00000, 24'h000000, 5'd24, 1'b0, 1'b0, 25);
        wait_idle();
        issue(20'h99999, 24'hFFFF58, 5'd0, 1'b1, 1'b0, 25);
        wait_idle();

        issue(20'h5A000, 24'h000000, 5'd24, 1'b0, 1'b1, 1);
        wait_idle();
        issue(20'h50000, 24'h800000, 5'd0, 1'b0, 1'b0, 25);
        wait_idle();
        issue(20'h0000F, 24'h000000, 5'd24, 1'b0, 1'b1, 1);
        wait_idle();

        issue(20'h10000, 24'h199999, 5'd3, 1'b1, 1'b0, 25);
        for (int i = 0; i < 8; i++) begin
            chk("busy_ready", 32'(bus.ready), 32'd0);
            bus.start  = 1'b1;
            bus.bcd_in = junk[i % 4];
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();

        issue(20'h25000, 24'h400000, 5'd1, 1'b0, 1'b0, 25);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        chk_reset_outputs("held_reset");
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_done_after_reset", 32'(bus.frac_out), 32'd0);
        issue(20'h50000, 24'h800000, 5'd0, 1'b0, 1'b0, 25);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
